// File: rtl/muldiv_if.sv
// ---------------------------------------------------------------------------
// muldiv_if
// Bundle between the E-stage issue logic and the multiply/divide unit.
//   start  : one-cycle launch strobe for a compute op
//   md_op  : 4-bit operation code (mult, multu, div, divu, mthi, mtlo, madd...)
//   A, B   : forwarded rs / rt operands
//   busy   : compute op in flight (fed to the hazard unit)
//   HI, LO : architectural HI/LO registers
// Modports: master drives the op, slave is the unit itself.
// ---------------------------------------------------------------------------
interface muldiv_if;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output start, md_op, A, B,
        input  busy, HI, LO
    );

    modport slave (
        input  start, md_op, A, B,
        output busy, HI, LO
    );
endinterface

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// muldiv_unit
// MIPS E-stage multiply/divide unit owning the HI/LO registers. Compute ops
// run for a fixed number of cycles (MULT_CYCLES / DIV_CYCLES) with busy high,
// then commit their result to HI/LO. mthi/mtlo write in a single cycle when
// the unit is idle.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high reset (aborts any op in flight)
//   md    : muldiv_if.slave (start, md_op, A, B in; busy, HI, LO out)
// Optional feature: define MULDIV_MADD_EN to enable madd/maddu/msub/msubu
// (md_op 7..10). Without it those codes never launch.
// ---------------------------------------------------------------------------
module muldiv_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic    clk,
    input  logic    reset,
    muldiv_if.slave md
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MULDIV_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    // How the pending 64-bit value is applied to {HI,LO} at commit.
    localparam logic [1:0] MODE_NONE = 2'd0;   // leave HI/LO alone (div by 0)
    localparam logic [1:0] MODE_LOAD = 2'd1;   // overwrite
    localparam logic [1:0] MODE_ADD  = 2'd2;   // accumulate
    localparam logic [1:0] MODE_SUB  = 2'd3;   // subtract

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [63:0] pend_q, pend_d;
    logic [1:0]  mode_q, mode_d;

    logic        launch_s;
    logic [63:0] l_pend_s;
    logic [1:0]  l_mode_s;
    logic [3:0]  l_cnt_s;

    // 64-bit product; operands are sign- or zero-extended so one unsigned
    // multiply serves both flavours.
    function automatic logic [63:0] mul64(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = sgn ? {{32{a[31]}}, a} : {32'd0, a};
        eb = sgn ? {{32{b[31]}}, b} : {32'd0, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}. Signed division is done on magnitudes so
    // 0x80000000 / -1 wraps cleanly to 0x80000000 with remainder 0, and a
    // zero divisor yields a defined (unused) value instead of X.
    function automatic logic [63:0] div64(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic        sgn);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] q;
        logic [31:0] r;
        neg_a = sgn & a[31];
        neg_b = sgn & b[31];
        mag_a = neg_a ? (32'd0 - a) : a;
        mag_b = neg_b ? (32'd0 - b) : b;
        if (mag_b == 32'd0) begin
            q = 32'd0;
            r = 32'd0;
        end else begin
            q = mag_a / mag_b;
            r = mag_a % mag_b;
        end
        q = (neg_a ^ neg_b) ? (32'd0 - q) : q;
        r = neg_a ? (32'd0 - r) : r;
        return {r, q};
    endfunction

    // Decode md_op into launch flag, pending result, commit mode and latency.
    always_comb begin
        launch_s = 1'b0;
        l_pend_s = 64'd0;
        l_mode_s = MODE_NONE;
        l_cnt_s  = 4'd0;
        case (md.md_op)
            OP_MULT, OP_MULTU: begin
                launch_s = 1'b1;
                l_pend_s = mul64(md.A, md.B, md.md_op == OP_MULT);
                l_mode_s = MODE_LOAD;
                l_cnt_s  = MULT_LOAD;
            end
            OP_DIV, OP_DIVU: begin
                launch_s = 1'b1;
                l_pend_s = div64(md.A, md.B, md.md_op == OP_DIV);
                l_mode_s = (md.B == 32'd0) ? MODE_NONE : MODE_LOAD;
                l_cnt_s  = DIV_LOAD;
            end
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU: begin
                launch_s = 1'b1;
                l_pend_s = mul64(md.A, md.B, md.md_op == OP_MADD);
                l_mode_s = MODE_ADD;
                l_cnt_s  = MULT_LOAD;
            end
            OP_MSUB, OP_MSUBU: begin
                launch_s = 1'b1;
                l_pend_s = mul64(md.A, md.B, md.md_op == OP_MSUB);
                l_mode_s = MODE_SUB;
                l_cnt_s  = MULT_LOAD;
            end
`endif
            default: begin
                launch_s = 1'b0;
            end
        endcase
    end

    // IDLE/RUN next-state logic, mthi/mtlo writes and HI/LO commit.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        mode_d  = mode_q;
        case (state_q)
            IDLE: begin
                if (md.start && launch_s) begin
                    state_d = RUN;
                    busy_d  = 1'b1;
                    cnt_d   = l_cnt_s;
                    pend_d  = l_pend_s;
                    mode_d  = l_mode_s;
                end else if (!md.start && (md.md_op == OP_MTHI)) begin
                    hi_d = md.A;
                end else if (!md.start && (md.md_op == OP_MTLO)) begin
                    lo_d = md.A;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (cnt_q == 4'd1) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    cnt_d   = 4'd0;
                    pend_d  = 64'd0;
                    mode_d  = MODE_NONE;
                    // Accumulate modes use HI/LO as they stand at commit.
                    case (mode_q)
                        MODE_LOAD: {hi_d, lo_d} = pend_q;
                        MODE_ADD:  {hi_d, lo_d} = {hi_q, lo_q} + pend_q;
                        MODE_SUB:  {hi_d, lo_d} = {hi_q, lo_q} - pend_q;
                        default:   {hi_d, lo_d} = {hi_q, lo_q};
                    endcase
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State, counter, pending result and HI/LO registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_q  <= 64'd0;
            mode_q  <= MODE_NONE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
            mode_q  <= mode_d;
        end
    end

    assign md.busy = busy_q;
    assign md.HI   = hi_q;
    assign md.LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// ---------------------------------------------------------------------------
// tb_muldiv_unit
// Scoreboard bench for muldiv_unit: each launched op pushes its expected
// HI/LO and busy length; a monitor pops on every falling edge of busy.
// Follows MULDIV_MADD_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_muldiv_unit;

    localparam int MC = 5;
    localparam int DC = 10;
`ifdef MULDIV_MADD_EN
    localparam bit MADD = 1'b1;
`else
    localparam bit MADD = 1'b0;
`endif

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          cycles;
    } exp_t;

    logic clk;
    logic reset;
    muldiv_if mif();

    muldiv_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .md    (mif)
    );

    exp_t        sb[$];
    int          errors;
    int          checks;
    logic [31:0] m_hi;
    logic [31:0] m_lo;
    bit          mon_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference model: architectural effect of an op, straight from the ISA rules.
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output bit launch, output int ncyc);
        int          da;
        int          db;
        longint      sp;
        logic [63:0] up;
        logic [63:0] acc;
        da = a;
        db = b;
        sp = longint'(da) * longint'(db);
        up = {32'd0, a} * {32'd0, b};
        acc = {m_hi, m_lo};
        launch = 1'b0;
        ncyc = 0;
        case (op)
            4'd1: begin launch = 1'b1; ncyc = MC; {m_hi, m_lo} = sp; end
            4'd2: begin launch = 1'b1; ncyc = MC; {m_hi, m_lo} = up; end
            4'd3: begin
                launch = 1'b1; ncyc = DC;
                if (b == 32'd0) begin
                    m_hi = m_hi;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    m_lo = 32'h8000_0000; m_hi = 32'd0;
                end else begin
                    m_lo = da / db; m_hi = da % db;
                end
            end
            4'd4: begin
                launch = 1'b1; ncyc = DC;
                if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
            end
            4'd7, 4'd8, 4'd9, 4'd10: begin
                if (MADD) begin
                    launch = 1'b1; ncyc = MC;
                    case (op)
                        4'd7:    acc = acc + 64'(sp);
                        4'd8:    acc = acc + up;
                        4'd9:    acc = acc - 64'(sp);
                        default: acc = acc - up;
                    endcase
                    {m_hi, m_lo} = acc;
                end
            end
            default: launch = 1'b0;
        endcase
    endtask

    // Issue a one-cycle start pulse the model expects to launch (or not).
    task automatic do_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        bit   l;
        int   n;
        exp_t e;
        model(op, a, b, l, n);
        if (l) begin
            e.hi = m_hi; e.lo = m_lo; e.cycles = n;
            sb.push_back(e);
        end
        mif.start = 1'b1; mif.md_op = op; mif.A = a; mif.B = b;
        cyc();
        mif.start = 1'b0; mif.md_op = 4'd0;
    endtask

    // Start pulse that must be ignored (busy, or non-compute code).
    task automatic pulse_ignored(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        mif.start = 1'b1; mif.md_op = op; mif.A = a; mif.B = b;
        cyc();
        mif.start = 1'b0; mif.md_op = 4'd0;
    endtask

    task automatic do_mt(input logic [3:0] op, input logic [31:0] a);
        if (op == 4'd5) m_hi = a; else m_lo = a;
        mif.start = 1'b0; mif.md_op = op; mif.A = a;
        cyc();
        mif.md_op = 4'd0;
        chk(op == 4'd5 ? "mthi_hi" : "mtlo_lo", op == 4'd5 ? mif.HI : mif.LO, a);
        chk("mt_busy", {31'd0, mif.busy}, 32'd0);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 40; i++) begin
            if (mif.busy !== 1'b1) break;
            cyc();
        end
        if (mif.busy === 1'b1) begin
            checks++; errors++;
            $display("FAIL busy_timeout: got busy=1 expected busy=0 within 40 cycles");
        end
    endtask

    function automatic logic [31:0] rnd_opnd();
        logic [31:0] v;
        case ($urandom_range(0, 7))
            0:       v = 32'd0;
            1:       v = 32'hFFFF_FFFF;
            2:       v = 32'h8000_0000;
            3:       v = 32'($urandom_range(0, 20));
            default: v = $urandom;
        endcase
        return v;
    endfunction

    // Monitor: measure each busy run and check the committed HI/LO.
    initial begin : monitor
        logic prev;
        int   run_len;
        exp_t e;
        prev = 1'b0;
        run_len = 0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (mif.busy === 1'b1) begin
                    if (!prev && sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL spurious_busy: got busy=1 expected busy=0 (no op launched)");
                    end
                    run_len++;
                end else if (prev) begin
                    if (sb.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_commit: got busy fall expected none");
                    end else begin
                        e = sb.pop_front();
                        chk("commit_hi", mif.HI, e.hi);
                        chk("commit_lo", mif.LO, e.lo);
                        chk("busy_len", 32'(run_len), 32'(e.cycles));
                    end
                    run_len = 0;
                end
                prev = (mif.busy === 1'b1);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1);
    end

    initial begin : stimulus
        errors = 0; checks = 0; mon_en = 1'b0;
        mif.start = 1'b0; mif.md_op = 4'd0; mif.A = 32'd0; mif.B = 32'd0;
        reset = 1'b1;
        repeat (3) cyc();
        reset = 1'b0;
        m_hi = 32'd0; m_lo = 32'd0;
        chk("reset_busy", {31'd0, mif.busy}, 32'd0);
        chk("reset_hi", mif.HI, 32'd0);
        chk("reset_lo", mif.LO, 32'd0);
        mon_en = 1'b1;

        // mult 7*6
        do_op(4'd1, 32'd7, 32'd6);
        chk("mult_busy_rise", {31'd0, mif.busy}, 32'd1);
        wait_idle();
        chk("mult76_hi", mif.HI, 32'd0);
        chk("mult76_lo", mif.LO, 32'd42);

        // signed vs unsigned multiply of -1 * 2
        do_op(4'd1, 32'hFFFF_FFFF, 32'd2); wait_idle();
        chk("mult_neg_hi", mif.HI, 32'hFFFF_FFFF);
        chk("mult_neg_lo", mif.LO, 32'hFFFF_FFFE);
        do_op(4'd2, 32'hFFFF_FFFF, 32'd2); wait_idle();
        chk("multu_hi", mif.HI, 32'h0000_0001);
        chk("multu_lo", mif.LO, 32'hFFFF_FFFE);

        // signed divide, divide by zero, overflow
        do_op(4'd3, 32'hFFFF_FFF9, 32'd2); wait_idle();
        chk("div_neg_lo", mif.LO, 32'hFFFF_FFFD);
        chk("div_neg_hi", mif.HI, 32'hFFFF_FFFF);
        do_op(4'd4, 32'd7, 32'd0); wait_idle();
        chk("divu0_lo", mif.LO, 32'hFFFF_FFFD);
        chk("divu0_hi", mif.HI, 32'hFFFF_FFFF);
        do_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
        chk("div_ovf_lo", mif.LO, 32'h8000_0000);
        chk("div_ovf_hi", mif.HI, 32'd0);

        // mthi / mtlo, and ignored starts
        do_mt(4'd5, 32'h1234_5678);
        do_mt(4'd6, 32'h0BAD_F00D);
        pulse_ignored(4'd5, 32'hDEAD_BEEF, 32'd0);
        chk("start_mthi_ignored", mif.HI, 32'h1234_5678);
        pulse_ignored(4'd0, 32'd3, 32'd3);
        chk("op0_no_busy", {31'd0, mif.busy}, 32'd0);
        do_op(4'd1, 32'd3, 32'd5);
        cyc();
        pulse_ignored(4'd3, 32'd100, 32'd7);
        wait_idle();
        chk("busy_start_hi", mif.HI, 32'd0);
        chk("busy_start_lo", mif.LO, 32'd15);

        // reset during busy cycle 3 of a div aborts it
        do_op(4'd3, 32'd100, 32'd7);
        cyc(); cyc();
        reset = 1'b1;
        sb.delete();
        sb.push_back('{32'd0, 32'd0, 3});
        m_hi = 32'd0; m_lo = 32'd0;
        cyc();
        reset = 1'b0;
        chk("abort_busy", {31'd0, mif.busy}, 32'd0);
        chk("abort_hi", mif.HI, 32'd0);
        chk("abort_lo", mif.LO, 32'd0);
        repeat (15) cyc();
        chk("abort_nocommit_hi", mif.HI, 32'd0);
        chk("abort_nocommit_lo", mif.LO, 32'd0);

        // madd: launches only with the feature enabled
        do_mt(4'd6, 32'hFFFF_FFFF);
        do_mt(4'd5, 32'd0);
        do_op(4'd7, 32'd1, 32'd1);
        chk("madd_busy", {31'd0, mif.busy}, {31'd0, MADD});
        wait_idle();
        chk("madd_hi", mif.HI, MADD ? 32'd1 : 32'd0);
        chk("madd_lo", mif.LO, MADD ? 32'd0 : 32'hFFFF_FFFF);

        // randomized mix
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 9) < 2) begin
                do_mt($urandom_range(0, 1) == 0 ? 4'd5 : 4'd6, $urandom);
            end else begin
                do_op(4'($urandom_range(1, 10)), rnd_opnd(), rnd_opnd());
                wait_idle();
                chk("rand_hi", mif.HI, m_hi);
                chk("rand_lo", mif.LO, m_lo);
            end
            repeat ($urandom_range(0, 2)) cyc();
        end

        repeat (3) cyc();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
